// File: rtl/hazard_sequencer.sv
// Stall/flush controller for the IF/ID and ID/EX pipeline registers; priority mem_busy > redirect > load-use.
// Latency: outputs are combinational from state and inputs, so a hazard acts in its detection cycle.
// Backpressure: mem_busy_i holds PC, IF/ID and ID/EX until it drops; there is no abort on timeout.
module hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 2,
    parameter int MEM_WAIT_MAX      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_hazard_i,
    input  logic        redirect_i,
    input  logic        mem_busy_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic [1:0]  state_o,
    output logic        timeout_o,
    output logic [15:0] stall_cnt_o
);

    localparam int LW = $clog2(LOAD_STALL_CYCLES + 1);
    localparam int FW = $clog2(BRANCH_PENALTY + 1);
    localparam int WW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_MEM   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [LW-1:0]   lcnt, lcnt_n;
    logic [FW-1:0]   fcnt, fcnt_n;
    logic [WW-1:0]   wcnt, wcnt_n;
    logic            timeout_q;
    logic [15:0]     stall_cnt;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic run_rules;

    always_comb begin
        state_n     = state;
        lcnt_n      = lcnt;
        fcnt_n      = fcnt;
        wcnt_n      = wcnt;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        run_rules   = 1'b0;

        case (state)
            ST_RUN: run_rules = 1'b1;
            ST_LOAD: begin
                // An older-stage event cancels the remaining bubbles.
                if (mem_busy_i || redirect_i) begin
                    run_rules = 1'b1;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    lcnt_n      = lcnt - LW'(1);
                    if (lcnt == LW'(1)) state_n = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // The ID instruction is being squashed, so its load-use hazard is moot.
                if (mem_busy_i) begin
                    run_rules = 1'b1;
                end else begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    fcnt_n      = fcnt - FW'(1);
                    if (fcnt == FW'(1)) state_n = ST_RUN;
                end
            end
            ST_MEM: begin
                if (mem_busy_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    if (wcnt != WW'(MEM_WAIT_MAX)) wcnt_n = wcnt + WW'(1);
                end else begin
                    run_rules = 1'b1;
                end
            end
            default: state_n = ST_RUN;
        endcase

        if (run_rules) begin
            if (mem_busy_i) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                state_n     = ST_MEM;
                wcnt_n      = WW'(1);
            end else if (redirect_i) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (BRANCH_PENALTY > 1) begin
                    state_n = ST_FLUSH;
                    fcnt_n  = FW'(BRANCH_PENALTY - 1);
                end else begin
                    state_n = ST_RUN;
                end
            end else if (load_hazard_i) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_n = ST_LOAD;
                    lcnt_n  = LW'(LOAD_STALL_CYCLES - 1);
                end else begin
                    state_n = ST_RUN;
                end
            end else begin
                state_n = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            lcnt      <= '0;
            fcnt      <= '0;
            wcnt      <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            lcnt  <= lcnt_n;
            fcnt  <= fcnt_n;
            wcnt  <= wcnt_n;
            if (state == ST_MEM && mem_busy_i && wcnt == WW'(MEM_WAIT_MAX))
                timeout_q <= 1'b1;
            if (pc_stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Gate with reset so a held-low reset releases every stall even while inputs are active.
    assign pc_stall_o    = rst & pc_stall;
    assign if_id_stall_o = rst & if_id_stall;
    assign if_id_flush_o = rst & if_id_flush;
    assign id_ex_stall_o = rst & id_ex_stall;
    assign id_ex_flush_o = rst & id_ex_flush;
    assign state_o       = state;
    assign timeout_o     = timeout_q;
    assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: default-parameter instance plus a LOAD_STALL_CYCLES=3 instance.
// Expected control vectors are queued as stimulus is driven and compared mid-cycle.
module tb_hazard_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_lh, a_rd, a_mb, b_lh, b_rd, b_mb;
    logic        a_pcs, a_iis, a_iif, a_ies, a_ief, a_to;
    logic        b_pcs, b_iis, b_iif, b_ies, b_ief, b_to;
    logic [1:0]  a_st, b_st;
    logic [15:0] a_cnt, b_cnt;

    hazard_sequencer dut_a (
        .clk(clk), .rst(rst),
        .load_hazard_i(a_lh), .redirect_i(a_rd), .mem_busy_i(a_mb),
        .pc_stall_o(a_pcs), .if_id_stall_o(a_iis), .if_id_flush_o(a_iif),
        .id_ex_stall_o(a_ies), .id_ex_flush_o(a_ief),
        .state_o(a_st), .timeout_o(a_to), .stall_cnt_o(a_cnt)
    );

    hazard_sequencer #(.LOAD_STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .load_hazard_i(b_lh), .redirect_i(b_rd), .mem_busy_i(b_mb),
        .pc_stall_o(b_pcs), .if_id_stall_o(b_iis), .if_id_flush_o(b_iif),
        .id_ex_stall_o(b_ies), .id_ex_flush_o(b_ief),
        .state_o(b_st), .timeout_o(b_to), .stall_cnt_o(b_cnt)
    );

    // ctl bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, state[1:0], timeout
    typedef struct packed {
        bit          sel;
        logic [7:0]  ctl;
        logic [7:0]  msk;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    task automatic push(input bit sel, input logic [7:0] ctl, input logic [7:0] msk);
        exp_t e;
        e.sel = sel;
        e.ctl = ctl;
        e.msk = msk;
        e.cnt = sel ? 16'(cnt_b) : 16'(cnt_a);
        q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t        e;
        logic [7:0]  o_ctl;
        logic [15:0] o_cnt;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty, got no expectation to compare", tag);
        end else begin
            e = q.pop_front();
            if (e.sel) begin
                o_ctl = {b_pcs, b_iis, b_iif, b_ies, b_ief, b_st, b_to};
                o_cnt = b_cnt;
            end else begin
                o_ctl = {a_pcs, a_iis, a_iif, a_ies, a_ief, a_st, a_to};
                o_cnt = a_cnt;
            end
            assert (((o_ctl & e.msk) === (e.ctl & e.msk)) && (o_cnt === e.cnt)) else begin
                n_err++;
                $error("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b (mask %b) cnt=%0d",
                       tag, o_ctl, o_cnt, e.ctl, e.msk, e.cnt);
            end
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cyc(input bit sel, input logic lh, input logic rd, input logic mb,
                       input logic [7:0] ctl, input logic [7:0] msk, input string tag);
        a_lh = sel ? 1'b0 : lh;  a_rd = sel ? 1'b0 : rd;  a_mb = sel ? 1'b0 : mb;
        b_lh = sel ? lh : 1'b0;  b_rd = sel ? rd : 1'b0;  b_mb = sel ? mb : 1'b0;
        push(sel, ctl, msk);
        @(negedge clk);
        check(tag);
        if (ctl[7]) begin
            if (sel) cnt_b++;
            else     cnt_a++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] c;
        logic [7:0] m;

        // Reset held low with every input active: all outputs must stay quiet.
        rst = 1'b0;
        a_lh = 1'b1; a_rd = 1'b1; a_mb = 1'b1;
        b_lh = 1'b1; b_rd = 1'b1; b_mb = 1'b1;
        #2;
        push(1'b0, 8'b00000_00_0, 8'hFF); check("reset_a");
        push(1'b1, 8'b00000_00_0, 8'hFF); check("reset_b");
        @(posedge clk); #1;
        rst = 1'b1;

        // Single-cycle load-use hazard
        cyc(0, 1, 0, 0, 8'b11001_00_0, 8'hFF, "load_pulse");
        cyc(0, 0, 0, 0, 8'b00000_00_0, 8'hFF, "load_after");

        // Redirect: two flush cycles, load hazard ignored during FLUSH
        cyc(0, 0, 1, 0, 8'b00101_00_0, 8'hFF, "redir_c1");
        cyc(0, 1, 0, 0, 8'b00101_10_0, 8'hFF, "redir_c2_ld_ignored");
        cyc(0, 0, 0, 0, 8'b00000_00_0, 8'hFF, "redir_done");

        // Memory busy for 20 cycles; timeout edge position left open around cycles 15-16
        for (int k = 1; k <= 20; k++) begin
            c = {5'b11010, (k == 1) ? 2'd0 : 2'd3, (k >= 17) ? 1'b1 : 1'b0};
            m = (k == 15 || k == 16) ? 8'hFE : 8'hFF;
            cyc(0, 0, 0, 1, c, m, $sformatf("mem_wait_%0d", k));
        end
        cyc(0, 0, 0, 0, 8'b00000_11_1, 8'hFF, "mem_release");
        cyc(0, 0, 0, 0, 8'b00000_00_1, 8'hFF, "timeout_sticky");

        // All three events together, then busy drops while redirect is high
        cyc(0, 1, 1, 1, 8'b11010_00_1, 8'hFF, "all_events");
        cyc(0, 0, 1, 0, 8'b00101_11_1, 8'hFF, "busy_drop_redir");
        cyc(0, 0, 0, 0, 8'b00101_10_1, 8'hFF, "post_redir_flush");
        cyc(0, 0, 0, 0, 8'b00000_00_1, 8'hFF, "post_redir_run");

        // LOAD_STALL_CYCLES=3: redirect in the second stall cycle
        cyc(1, 1, 0, 0, 8'b11001_00_0, 8'hFF, "ls3_stall1");
        cyc(1, 0, 1, 0, 8'b00101_01_0, 8'hFF, "ls3_redir_cancel");
        cyc(1, 0, 0, 0, 8'b00101_10_0, 8'hFF, "ls3_flush");
        cyc(1, 0, 0, 0, 8'b00000_00_0, 8'hFF, "ls3_run");
        // Uninterrupted three-bubble load stall
        cyc(1, 1, 0, 0, 8'b11001_00_0, 8'hFF, "ls3_full_1");
        cyc(1, 0, 0, 0, 8'b11001_01_0, 8'hFF, "ls3_full_2");
        cyc(1, 0, 0, 0, 8'b11001_01_0, 8'hFF, "ls3_full_3");
        cyc(1, 0, 0, 0, 8'b00000_00_0, 8'hFF, "ls3_full_end");

        // Asynchronous reset in the middle of a memory wait
        cyc(0, 0, 0, 1, 8'b11010_00_1, 8'hFF, "pre_rst_busy1");
        a_mb = 1'b1;
        #2;
        push(0, 8'b11010_11_1, 8'hFF); check("pre_rst_busy2");
        rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        #1;
        push(0, 8'b00000_00_0, 8'hFF); check("mid_rst_a");
        push(1, 8'b00000_00_0, 8'hFF); check("mid_rst_b");
        @(posedge clk); #1;
        rst  = 1'b1;
        a_mb = 1'b0;
        cyc(0, 0, 0, 0, 8'b00000_00_0, 8'hFF, "post_rst_idle");
        cyc(0, 1, 0, 0, 8'b11001_00_0, 8'hFF, "post_rst_load");
        cyc(0, 0, 0, 0, 8'b00000_00_0, 8'hFF, "post_rst_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
